// File: rtl/sonar_quadro_tx_pkg.sv
// Shared definitions for the sonar frame transmitter.
// Holds the FSM state encoding (also exported on db_estado), the ASCII
// constants used to build a frame, and the digit-to-ASCII helper.
package sonar_quadro_tx_pkg;

  typedef enum logic [3:0] {
    INICIAL         = 4'd0,
    DISPARA         = 4'd1,
    ESPERA_MEDIDA   = 4'd2,
    CAPTURA         = 4'd3,
    TRANSMITE       = 4'd4,
    ESPERA_TX       = 4'd5,
    PROXIMO         = 4'd6,
    FINAL_QUADRO    = 4'd7,
    AGUARDA_PERIODO = 4'd8
  } estado_t;

  // ASCII '0'..'9' is {3'b011, bcd}
  localparam logic [2:0] ASCII_PREFIXO_DIGITO = 3'b011;
  localparam logic [6:0] ASCII_INTERROGACAO   = 7'h3F;  // '?'
  localparam logic [6:0] ASCII_SEP_PADRAO     = 7'h2C;  // ','
  localparam logic [6:0] ASCII_FIM_PADRAO     = 7'h23;  // '#'

  // A channel that timed out reports '?' in place of every digit.
  function automatic logic [6:0] digito_ascii(input logic [3:0] bcd, input logic falha);
    return falha ? ASCII_INTERROGACAO : {ASCII_PREFIXO_DIGITO, bcd};
  endfunction

endpackage

// File: rtl/contador_m.sv
// Saturating up-counter with terminal flag, used for the period and
// timeout timers.
// Ports:
//   clock - system clock
//   reset - asynchronous active-low reset (clears the count)
//   zera  - synchronous clear, has priority over conta
//   conta - count enable; the count holds once it reaches M-1
//   fim   - high while the count equals M-1
module contador_m #(
  parameter int M = 16,
  parameter int W = (M > 1) ? $clog2(M) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (zera) begin
      q_d = '0;
    end else if (conta && (q_q != ULTIMO)) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign fim = (q_q == ULTIMO);

endmodule

// File: rtl/sonar_quadro_tx.sv
// Multi-channel ultrasonic measurement frame transmitter.
// Fires all sensors, waits for their ready pulses (or a timeout), captures
// the BCD readings and sends them one ASCII character at a time as
// "ddd,ddd,...,ddd#", optionally repeating every PERIODO cycles.
// Ports:
//   clock, reset     - system clock, asynchronous active-low reset
//   modo             - 0 single-shot, 1 periodic
//   iniciar          - start request (only honoured in inicial)
//   medidas          - packed BCD readings, channel 0 in the LSBs
//   prontos          - per-channel ready pulses
//   pronto_serial    - serial transmitter finished the current character
//   medir            - trigger pulse to all sensors
//   partida_tx       - start pulse to serial transmitter
//   dados_ascii      - character being transmitted
//   ocupado          - frame in progress
//   fim_quadro       - frame terminator accepted
//   db_falha         - channels that timed out in the last frame
//   db_estado        - current FSM state code
module sonar_quadro_tx
  import sonar_quadro_tx_pkg::*;
#(
  parameter int         N_CH    = 3,
  parameter int         DIGITOS = 3,
  parameter int         PERIODO = 50_000_000,
  parameter int         TIMEOUT = 2_500_000,
  parameter logic [6:0] SEP     = ASCII_SEP_PADRAO,
  parameter logic [6:0] FIM     = ASCII_FIM_PADRAO
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      modo,
  input  logic                      iniciar,
  input  logic [N_CH*4*DIGITOS-1:0] medidas,
  input  logic [N_CH-1:0]           prontos,
  input  logic                      pronto_serial,
  output logic                      medir,
  output logic                      partida_tx,
  output logic [6:0]                dados_ascii,
  output logic                      ocupado,
  output logic                      fim_quadro,
  output logic [N_CH-1:0]           db_falha,
  output logic [3:0]                db_estado
);

  localparam int            LEN     = N_CH * (DIGITOS + 1);
  localparam int            IW      = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IW-1:0] ULTIMO  = IW'(LEN - 1);

  estado_t                     estado_q, estado_d;
  logic [N_CH-1:0]             flags_q, flags_d;
  logic [N_CH*4*DIGITOS-1:0]   dados_q, dados_d;
  logic [N_CH-1:0]             falha_q, falha_d;
  logic [IW-1:0]               idx_q, idx_d;

  logic periodo_fim;
  logic timeout_fim;
  logic zera_timers;
  logic conta_timeout;

  // Both timers restart together with the medir pulse, so the cycle in
  // dispara is already count 0. That makes medir-to-medir exactly PERIODO
  // and dispara-to-captura exactly TIMEOUT.
  assign zera_timers   = (estado_d == DISPARA);
  assign conta_timeout = (estado_q == DISPARA) || (estado_q == ESPERA_MEDIDA);

  contador_m #(.M(PERIODO)) u_periodo (
    .clock (clock),
    .reset (reset),
    .zera  (zera_timers),
    .conta (1'b1),
    .fim   (periodo_fim)
  );

  contador_m #(.M(TIMEOUT)) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (zera_timers),
    .conta (conta_timeout),
    .fim   (timeout_fim)
  );

  // Whole frame laid out as a character table over the captured data;
  // the separator slot of the last channel carries the terminator.
  logic [6:0] quadro [LEN];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_canal
    for (genvar gj = 0; gj < DIGITOS; gj++) begin : g_digito
      assign quadro[gi*(DIGITOS+1) + gj] =
        digito_ascii(dados_q[gi*4*DIGITOS + (DIGITOS-1-gj)*4 +: 4], falha_q[gi]);
    end
    assign quadro[gi*(DIGITOS+1) + DIGITOS] = (gi == N_CH - 1) ? FIM : SEP;
  end

  always_comb begin
    estado_d = estado_q;
    flags_d  = flags_q;
    dados_d  = dados_q;
    falha_d  = falha_q;
    idx_d    = idx_q;
    case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = DISPARA;
      end
      DISPARA: begin
        flags_d  = '0;
        estado_d = ESPERA_MEDIDA;
      end
      ESPERA_MEDIDA: begin
        // flags_d already includes this cycle's pulses, so a pronto that
        // coincides with the timeout still counts as ready.
        flags_d = flags_q | prontos;
        if ((&flags_d) || timeout_fim) estado_d = CAPTURA;
      end
      CAPTURA: begin
        dados_d  = medidas;
        falha_d  = ~flags_q;
        idx_d    = '0;
        estado_d = TRANSMITE;
      end
      TRANSMITE: begin
        estado_d = ESPERA_TX;
      end
      ESPERA_TX: begin
        if (pronto_serial) estado_d = PROXIMO;
      end
      PROXIMO: begin
        if (idx_q == ULTIMO) begin
          estado_d = FINAL_QUADRO;
        end else begin
          idx_d    = idx_q + 1'b1;
          estado_d = TRANSMITE;
        end
      end
      FINAL_QUADRO: begin
        estado_d = modo ? AGUARDA_PERIODO : INICIAL;
      end
      AGUARDA_PERIODO: begin
        if (!modo) begin
          estado_d = INICIAL;
        end else if (periodo_fim) begin
          estado_d = DISPARA;
        end
      end
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
      flags_q  <= '0;
      dados_q  <= '0;
      falha_q  <= '0;
      idx_q    <= '0;
    end else begin
      estado_q <= estado_d;
      flags_q  <= flags_d;
      dados_q  <= dados_d;
      falha_q  <= falha_d;
      idx_q    <= idx_d;
    end
  end

  assign medir       = (estado_q == DISPARA);
  assign partida_tx  = (estado_q == TRANSMITE);
  assign fim_quadro  = (estado_q == FINAL_QUADRO);
  assign ocupado     = (estado_q != INICIAL) && (estado_q != AGUARDA_PERIODO);
  assign dados_ascii = ((estado_q == TRANSMITE) || (estado_q == ESPERA_TX)) ? quadro[idx_q] : 7'h00;
  assign db_falha    = falha_q;
  assign db_estado   = estado_q;

endmodule
